// File: rtl/oled_pkg.sv
// Shared definitions for the OLED burst writer: SSD1306/SH1106 addressing
// command opcodes and the writer's state encoding.
package oled_pkg;

  localparam logic [7:0] CMD_PAGE = 8'hB0;  // set page address, low nibble = page
  localparam logic [7:0] CMD_COLH = 8'h10;  // set column high nibble
  localparam logic [7:0] CMD_COLL = 8'h00;  // set column low nibble

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StPage = 3'd1,
    StColh = 3'd2,
    StColl = 3'd3,
    StData = 3'd4,
    StNext = 3'd5,
    StDone = 3'd6
  } state_e;

endpackage

// File: rtl/oled_addr_cmd.sv
// Combinational encoder for the three addressing command bytes.
// Ports:
//   x        in  8  current column (before offset)
//   y        in  4  current page
//   page_cmd out 8  0xB0 | y
//   colh_cmd out 8  0x10 | c[7:4]
//   coll_cmd out 8  c[3:0], with c = (x + COL_OFFSET) mod 256
module oled_addr_cmd
  import oled_pkg::*;
#(
  parameter int unsigned COL_OFFSET = 0
) (
  input  logic [7:0] x,
  input  logic [3:0] y,
  output logic [7:0] page_cmd,
  output logic [7:0] colh_cmd,
  output logic [7:0] coll_cmd
);

  logic [7:0] col;

  // SH1106 panels map visible column 0 to RAM column COL_OFFSET; mod 256 wrap.
  assign col      = x + 8'(COL_OFFSET);
  assign page_cmd = CMD_PAGE | {4'h0, y};
  assign colh_cmd = CMD_COLH | {4'h0, col[7:4]};
  assign coll_cmd = CMD_COLL | {4'h0, col[3:0]};

endmodule

// File: rtl/oled_write_burst.sv
// OLED data-burst writer. Captures a start position and NBYTES column bytes on
// write_start, sends page/column addressing commands, then streams the data,
// re-addressing whenever the column runs off the right panel edge.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   write_start         start request, sampled only when idle
//   write_data          burst bytes, byte 0 in the top 8 bits, sent first
//   set_pos_x/set_pos_y start column / page (low log2(PAGES) bits of page used)
//   invert              send data bytes XOR 0xFF, captured at start
//   spi_send/spi_data   byte request and byte to the SPI sender
//   dc                  0 = command byte, 1 = display data
//   send_done           SPI sender accepted the current byte
//   busy                high whenever not idle
//   write_done          one-cycle pulse at burst end
module oled_write_burst
  import oled_pkg::*;
#(
  parameter int unsigned NBYTES     = 6,
  parameter int unsigned COLS       = 128,
  parameter int unsigned PAGES      = 8,
  parameter int unsigned COL_OFFSET = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                write_start,
  input  logic [8*NBYTES-1:0] write_data,
  input  logic [7:0]          set_pos_x,
  input  logic [7:0]          set_pos_y,
  input  logic                invert,
  output logic                spi_send,
  output logic [7:0]          spi_data,
  output logic                dc,
  input  logic                send_done,
  output logic                busy,
  output logic                write_done
);

  localparam int unsigned PW = (PAGES > 1) ? $clog2(PAGES) : 1;
  localparam int unsigned DW = 8 * NBYTES;

  state_e          state_q, state_d;
  logic [7:0]      x_q, x_d;
  logic [PW-1:0]   y_q, y_d;
  logic [DW-1:0]   data_q, data_d;
  logic            inv_q, inv_d;
  logic [7:0]      cnt_q, cnt_d;

  logic [8:0]      x_inc;
  logic [7:0]      cnt_inc;
  logic [PW-1:0]   y_start;
  logic            start_x_wrap;
  logic [7:0]      page_cmd, colh_cmd, coll_cmd;
  logic            unused_pos_y;

  // A single-page panel always addresses page 0.
  function automatic logic [PW-1:0] page_inc(input logic [PW-1:0] p);
    return (PAGES == 1) ? '0 : p + PW'(1);
  endfunction

  assign x_inc        = {1'b0, x_q} + 9'd1;
  assign cnt_inc      = cnt_q + 8'd1;
  assign y_start      = (PAGES == 1) ? '0 : set_pos_y[PW-1:0];
  assign start_x_wrap = ({1'b0, set_pos_x} >= 9'(COLS));
  assign unused_pos_y = ^set_pos_y;

  oled_addr_cmd #(
    .COL_OFFSET (COL_OFFSET)
  ) u_addr_cmd (
    .x        (x_q),
    .y        (4'(y_q)),
    .page_cmd (page_cmd),
    .colh_cmd (colh_cmd),
    .coll_cmd (coll_cmd)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    data_d  = data_q;
    inv_d   = inv_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (write_start) begin
          data_d = write_data;
          inv_d  = invert;
          // An off-panel start column begins at the left edge of the next page.
          if (start_x_wrap) begin
            x_d = '0;
            y_d = page_inc(y_start);
          end else begin
            x_d = set_pos_x;
            y_d = y_start;
          end
          state_d = StPage;
        end
      end
      StPage: if (send_done) state_d = StColh;
      StColh: if (send_done) state_d = StColl;
      StColl: if (send_done) state_d = StData;
      StData: if (send_done) state_d = StNext;
      StNext: begin
        data_d = data_q << 8;
        cnt_d  = cnt_inc;
        if (cnt_inc == 8'(NBYTES)) begin
          x_d     = x_inc[7:0];
          state_d = StDone;
        end else if (x_inc == 9'(COLS)) begin
          x_d     = '0;
          y_d     = page_inc(y_q);
          state_d = StPage;
        end else begin
          // The panel auto-increments its column pointer; no re-addressing.
          x_d     = x_inc[7:0];
          state_d = StData;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      data_q  <= '0;
      inv_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      data_q  <= data_d;
      inv_q   <= inv_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode only registered state, so they hold steady through a send.
  always_comb begin
    spi_send = 1'b0;
    spi_data = 8'h00;
    dc       = 1'b0;
    case (state_q)
      StPage: begin
        spi_send = 1'b1;
        spi_data = page_cmd;
      end
      StColh: begin
        spi_send = 1'b1;
        spi_data = colh_cmd;
      end
      StColl: begin
        spi_send = 1'b1;
        spi_data = coll_cmd;
      end
      StData: begin
        spi_send = 1'b1;
        dc       = 1'b1;
        spi_data = data_q[DW-1 -: 8] ^ {8{inv_q}};
      end
      default: ;
    endcase
  end

  assign busy       = (state_q != StIdle);
  assign write_done = (state_q == StDone);

endmodule

// File: tb/tb_oled_write_burst.sv
// Bench for oled_write_burst: two instances (6-byte/offset 0 and 4-byte/offset 2)
// share stimulus; accepted bytes are captured and compared with hand tables and
// with a byte-list reference model.
module tb_oled_write_burst;

  logic        clk = 1'b0;
  logic        reset;
  logic        write_start;
  logic [47:0] write_data;
  logic [7:0]  set_pos_x, set_pos_y;
  logic        invert;
  logic        send_done;

  logic       spi_send_a, dc_a, busy_a, write_done_a;
  logic [7:0] spi_data_a;
  logic       spi_send_b, dc_b, busy_b, write_done_b;
  logic [7:0] spi_data_b;

  int n_pass  = 0;
  int n_total = 0;
  int ack_mode = 0;
  int dly = 0;
  int wd_a, wd_b;
  logic [8:0] cap_a[$], cap_b[$], exp_a[$], exp_b[$];
  bit hold_a = 0, hold_b = 0;
  logic [7:0] last_a, last_b;

  always #5 clk = ~clk;

  oled_write_burst #(
    .NBYTES (6), .COLS (128), .PAGES (8), .COL_OFFSET (0)
  ) u_dut_a (
    .clk (clk), .reset (reset), .write_start (write_start), .write_data (write_data),
    .set_pos_x (set_pos_x), .set_pos_y (set_pos_y), .invert (invert),
    .spi_send (spi_send_a), .spi_data (spi_data_a), .dc (dc_a), .send_done (send_done),
    .busy (busy_a), .write_done (write_done_a)
  );

  oled_write_burst #(
    .NBYTES (4), .COLS (128), .PAGES (8), .COL_OFFSET (2)
  ) u_dut_b (
    .clk (clk), .reset (reset), .write_start (write_start), .write_data (write_data[47:16]),
    .set_pos_x (set_pos_x), .set_pos_y (set_pos_y), .invert (invert),
    .spi_send (spi_send_b), .spi_data (spi_data_b), .dc (dc_b), .send_done (send_done),
    .busy (busy_b), .write_done (write_done_b)
  );

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endfunction

  // Acknowledge policy: 0 = always ready, 1 = random, 2 = one accept every 6 cycles.
  always @(posedge clk) begin
    #1;
    dly = (dly == 5) ? 0 : dly + 1;
    case (ack_mode)
      0:       send_done = 1'b1;
      1:       send_done = ($urandom_range(0, 2) == 0);
      default: send_done = (dly == 5);
    endcase
  end

  // Capture accepted bytes; a pending request must hold its byte.
  always @(negedge clk) begin
    if (reset) begin
      hold_a = 0;
      hold_b = 0;
    end else begin
      if (spi_send_a) begin
        if (hold_a) check("a_data_stable", 32'(spi_data_a), 32'(last_a));
        if (send_done) begin
          cap_a.push_back({dc_a, spi_data_a});
          hold_a = 0;
        end else begin
          hold_a = 1;
          last_a = spi_data_a;
        end
      end else hold_a = 0;
      if (spi_send_b) begin
        if (hold_b) check("b_data_stable", 32'(spi_data_b), 32'(last_b));
        if (send_done) begin
          cap_b.push_back({dc_b, spi_data_b});
          hold_b = 0;
        end else begin
          hold_b = 1;
          last_b = spi_data_b;
        end
      end else hold_b = 0;
      if (write_done_a) wd_a++;
      if (write_done_b) wd_b++;
    end
  end

  function automatic void push(input int sel, input logic [8:0] v);
    if (sel == 0) exp_a.push_back(v);
    else exp_b.push_back(v);
  endfunction

  // Reference: list of {dc, byte} the panel should receive for one burst.
  function automatic void model(input int sel, input int nb, input int off, input logic [47:0] d,
                                input int x, input int y, input bit inv);
    int xx, yy, c;
    bit addr;
    logic [7:0] b;
    xx = x;
    yy = y % 8;
    if (xx >= 128) begin
      xx = 0;
      yy = (yy + 1) % 8;
    end
    addr = 1;
    for (int i = 0; i < nb; i++) begin
      if (addr) begin
        c = (xx + off) % 256;
        push(sel, {1'b0, 8'(176 + yy)});
        push(sel, {1'b0, 8'(16 + c / 16)});
        push(sel, {1'b0, 8'(c % 16)});
        addr = 0;
      end
      b = 8'(d >> (8 * (nb - 1 - i)));
      push(sel, {1'b1, inv ? ~b : b});
      xx++;
      if (xx == 128) begin
        xx = 0;
        yy = (yy + 1) % 8;
        addr = 1;
      end
    end
  endfunction

  task automatic compare_all();
    check("a_len", 32'(cap_a.size()), 32'(exp_a.size()));
    for (int i = 0; i < exp_a.size() && i < cap_a.size(); i++)
      check($sformatf("a_byte%0d", i), 32'(cap_a[i]), 32'(exp_a[i]));
    check("b_len", 32'(cap_b.size()), 32'(exp_b.size()));
    for (int i = 0; i < exp_b.size() && i < cap_b.size(); i++)
      check($sformatf("b_byte%0d", i), 32'(cap_b[i]), 32'(exp_b[i]));
  endtask

  task automatic start_burst(input logic [7:0] x, input logic [7:0] y, input logic [47:0] d,
                             input bit inv, input int mode);
    @(posedge clk);
    #1;
    ack_mode    = mode;
    set_pos_x   = x;
    set_pos_y   = y;
    write_data  = d;
    invert      = inv;
    cap_a.delete();
    cap_b.delete();
    wd_a        = 0;
    wd_b        = 0;
    write_start = 1'b1;
    @(posedge clk);
    #1;
    write_start = 1'b0;
    @(negedge clk);
    check("a_send_latency", 32'(spi_send_a), 32'd1);
    check("b_send_latency", 32'(spi_send_b), 32'd1);
  endtask

  task automatic run_burst(input logic [7:0] x, input logic [7:0] y, input logic [47:0] d,
                           input bit inv, input int mode, input bit extra);
    start_burst(x, y, d, inv, mode);
    for (int cyc = 0; cyc < 3000 && !(wd_a > 0 && wd_b > 0); cyc++) begin
      @(posedge clk);
      #1;
      if (extra && cyc == 20) begin
        write_start = 1'b1;
        set_pos_x   = 8'd50;
      end else write_start = 1'b0;
    end
    check("burst_done_in_time", 32'(wd_a > 0 && wd_b > 0), 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("a_busy_after", 32'(busy_a), 32'd0);
    check("b_busy_after", 32'(busy_b), 32'd0);
    check("a_write_done_count", 32'(wd_a), 32'd1);
    check("b_write_done_count", 32'(wd_b), 32'd1);
    compare_all();
  endtask

  typedef struct {
    logic [7:0]  x;
    logic [7:0]  y;
    logic [47:0] d;
    bit          inv;
    int          mode;
    bit          extra;
    int          n;
    logic [95:0] bytes;  // instance A bytes, first byte in the top 8 bits
    logic [11:0] dcs;    // matching dc bits, first byte in bit 11
  } vec_t;

  vec_t tbl[5];

  initial begin
    reset = 1'b1; write_start = 1'b0; write_data = '0; set_pos_x = '0; set_pos_y = '0;
    invert = 1'b0; send_done = 1'b0;
    tbl[0] = '{8'd0, 8'd0, 48'h0102030405A5, 1'b0, 0, 1'b0, 9,
               96'hB0_10_00_01_02_03_04_05_A5_00_00_00, 12'b000111111000};
    tbl[1] = '{8'd126, 8'd2, 48'h112233445566, 1'b0, 0, 1'b0, 12,
               96'hB2_17_0E_11_22_B3_10_00_33_44_55_66, 12'b000110001111};
    tbl[2] = '{8'd127, 8'd7, 48'hAABBCCDDEEFF, 1'b0, 1, 1'b0, 12,
               96'hB7_17_0F_AA_B0_10_00_BB_CC_DD_EE_FF, 12'b000100011111};
    tbl[3] = '{8'h1F, 8'd0, 48'h0F0000000000, 1'b1, 2, 1'b1, 9,
               96'hB0_11_0F_F0_FF_FF_FF_FF_FF_00_00_00, 12'b000111111000};
    tbl[4] = '{8'd200, 8'd7, 48'h0102030405A5, 1'b0, 1, 1'b0, 9,
               96'hB0_10_00_01_02_03_04_05_A5_00_00_00, 12'b000111111000};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_a_spi_send", 32'(spi_send_a), 32'd0);
    check("rst_a_spi_data", 32'(spi_data_a), 32'd0);
    check("rst_a_dc", 32'(dc_a), 32'd0);
    check("rst_a_busy", 32'(busy_a), 32'd0);
    check("rst_a_write_done", 32'(write_done_a), 32'd0);
    check("rst_b_spi_send", 32'(spi_send_b), 32'd0);
    check("rst_b_busy", 32'(busy_b), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      vec_t t;
      t = tbl[i];
      exp_a.delete();
      exp_b.delete();
      for (int k = 0; k < t.n; k++) exp_a.push_back({t.dcs[11-k], t.bytes[95-8*k -: 8]});
      model(1, 4, 2, {16'h0, t.d[47:16]}, int'(t.x), int'(t.y), t.inv);
      run_burst(t.x, t.y, t.d, t.inv, t.mode, t.extra);
    end

    // Reset while the 4th data byte is pending.
    start_burst(8'd0, 8'd0, 48'h102030405060, 1'b0, 2);
    for (int cyc = 0; cyc < 1000 && cap_a.size() < 6; cyc++) @(negedge clk);
    check("reset_test_reached_byte4", 32'(cap_a.size()), 32'd6);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_a_spi_send", 32'(spi_send_a), 32'd0);
    check("midrst_a_busy", 32'(busy_a), 32'd0);
    check("midrst_a_dc", 32'(dc_a), 32'd0);
    check("midrst_b_spi_send", 32'(spi_send_b), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("midrst_a_write_done", 32'(write_done_a), 32'd0);
    check("midrst_no_done_pulse", 32'(wd_a), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_a.delete();
    exp_b.delete();
    model(0, 6, 0, 48'hC1C2C3C4C5C6, 0, 0, 1'b0);
    model(1, 4, 2, {16'h0, 32'hC1C2C3C4}, 0, 0, 1'b0);
    run_burst(8'd0, 8'd0, 48'hC1C2C3C4C5C6, 1'b0, 0, 1'b0);

    // Randomized bursts, biased toward the right panel edge.
    for (int r = 0; r < 8; r++) begin
      logic [7:0]  rx, ry;
      logic [47:0] rd;
      bit          rinv;
      int          rmode;
      rx    = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(120, 135)) : 8'($urandom_range(0, 255));
      ry    = 8'($urandom_range(0, 255));
      rd    = {16'($urandom), $urandom};
      rinv  = 1'($urandom_range(0, 1));
      rmode = $urandom_range(0, 2);
      exp_a.delete();
      exp_b.delete();
      model(0, 6, 0, rd, int'(rx), int'(ry), rinv);
      model(1, 4, 2, {16'h0, rd[47:16]}, int'(rx), int'(ry), rinv);
      run_burst(rx, ry, rd, rinv, rmode, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
